// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared scan-code constants, parser states and table helper
package kbd_pkg;

  // PS/2 set-2 prefix and error bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;

  // Bytes that follow the leading E1 of the Pause sequence
  localparam int SC_PAUSE_SKIP = 7;

  // Largest table the helper can address (channels)
  localparam int MAX_KEYS    = 64;
  localparam int MAX_TABLE_W = MAX_KEYS * 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } parse_state_t;

  // Entry {ext, byte} for channel k, alias a
  function automatic logic [8:0] code_entry(input logic [MAX_TABLE_W-1:0] tbl,
                                            input int k, input int a);
    return tbl[(2*k+a)*9 +: 9];
  endfunction

endpackage

// File: rtl/kbd_repeat_timer.sv
// rtl/kbd_repeat_timer.sv - per-channel auto-repeat down-counter
module kbd_repeat_timer #(
  parameter int               CNT_W = 8,
  parameter logic [CNT_W-1:0] DELAY = '0,
  parameter logic [CNT_W-1:0] RATE  = CNT_W'(1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic tick,
  input  logic enable,
  output logic fire
);

  logic [CNT_W-1:0] cnt;

  // A tick that finds the counter at 1 produces a repeat
  assign fire = enable && tick && (cnt == CNT_W'(1));

  // Counter: clear on break, load on fresh make, count ticks while enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= DELAY;
    end else if (enable && tick && (cnt != '0)) begin
      cnt <= fire ? RATE : cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/kbd_event_mapper.sv
// rtl/kbd_event_mapper.sv - PS/2 scan-code parser, key table match and event flags
module kbd_event_mapper
  import kbd_pkg::*;
#(
  parameter int                    N_KEYS       = 9,
  parameter logic [N_KEYS*18-1:0]  CODE_TABLE   = '0,
  parameter int                    REPEAT_DELAY = 25,
  parameter int                    REPEAT_RATE  = 5,
  parameter int                    CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              tick,
  input  logic              repeat_en,
  input  logic              evt_ack,
  output logic [N_KEYS-1:0] key_held,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] evt_pending,
  output logic              evt_overrun
);

  localparam logic [MAX_TABLE_W-1:0] TBL     = MAX_TABLE_W'(CODE_TABLE);
  localparam logic [CNT_W-1:0]       DELAY_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]       RATE_C  = CNT_W'(REPEAT_RATE);
  localparam logic                   RPT_ON  = (REPEAT_DELAY != 0);

  parse_state_t state;
  logic [2:0]   skip_cnt;
  logic         err_byte;
  logic         code_valid;
  logic         code_brk;
  logic [8:0]   code;

  logic [N_KEYS-1:0] make_new;
  logic [N_KEYS-1:0] brk_hit;
  logic [N_KEYS-1:0] rpt_fire;
  logic [N_KEYS-1:0] evt;

  assign err_byte = (rx_byte == SC_ERR0) || (rx_byte == SC_ERR1);

  // Decode whether this byte completes a make or break code
  always_comb begin
    code_valid = 1'b0;
    code_brk   = 1'b0;
    code       = {1'b0, rx_byte};
    if (rx_valid && !err_byte) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte != SC_EXT && rx_byte != SC_BRK && rx_byte != SC_PAUSE)
            code_valid = 1'b1;
        end
        ST_EXT: begin
          if (rx_byte != SC_BRK) begin
            code_valid = 1'b1;
            code       = {1'b1, rx_byte};
          end
        end
        ST_BRK: begin
          code_valid = 1'b1;
          code_brk   = 1'b1;
        end
        ST_EXT_BRK: begin
          code_valid = 1'b1;
          code_brk   = 1'b1;
          code       = {1'b1, rx_byte};
        end
        default: ;
      endcase
    end
  end

  // Prefix parser; error bytes abandon any partial code
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else if (rx_valid) begin
      if (err_byte) begin
        state    <= ST_IDLE;
        skip_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_byte == SC_EXT) begin
              state <= ST_EXT;
            end else if (rx_byte == SC_BRK) begin
              state <= ST_BRK;
            end else if (rx_byte == SC_PAUSE) begin
              state    <= ST_SKIP;
              skip_cnt <= 3'(SC_PAUSE_SKIP);
            end
          end
          ST_EXT:     state <= (rx_byte == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
          ST_BRK:     state <= ST_IDLE;
          ST_EXT_BRK: state <= ST_IDLE;
          ST_SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt <= 3'd1)
              state <= ST_IDLE;
          end
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

  // Per-channel table match and repeat timer; duplicate entries fan out
  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    localparam logic [8:0] ENT0 = code_entry(TBL, k, 0);
    localparam logic [8:0] ENT1 = code_entry(TBL, k, 1);

    logic hit;
    assign hit = code_valid &&
                 (((ENT0 != 9'h000) && (ENT0 == code)) ||
                  ((ENT1 != 9'h000) && (ENT1 == code)));
    assign make_new[k] = hit && !code_brk && !key_held[k];
    assign brk_hit[k]  = hit && code_brk;

    kbd_repeat_timer #(
      .CNT_W (CNT_W),
      .DELAY (DELAY_C),
      .RATE  (RATE_C)
    ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (make_new[k]),
      .clear  (brk_hit[k]),
      .tick   (tick),
      .enable (repeat_en && key_held[k] && RPT_ON),
      .fire   (rpt_fire[k])
    );
  end

  // A break in the same cycle as a repeat suppresses the repeat
  assign evt = make_new | (rpt_fire & ~brk_hit);

  // Registered key state, press pulses and sticky pending flags
  always_ff @(posedge clk) begin
    if (reset) begin
      key_held    <= '0;
      key_press   <= '0;
      evt_pending <= '0;
      evt_overrun <= 1'b0;
    end else begin
      key_held    <= (key_held | make_new) & ~brk_hit;
      key_press   <= evt;
      evt_pending <= (evt_pending & ~{N_KEYS{evt_ack}}) | evt;
      evt_overrun <= (|(evt & evt_pending)) && !evt_ack;
    end
  end

endmodule

// File: tb/tb_kbd_event_mapper.sv
// tb/tb_kbd_event_mapper.sv - directed bench with behavioural model for kbd_event_mapper
module tb_kbd_event_mapper;

  localparam int NK = 4;
  localparam int DLY = 3;
  localparam int RTE = 2;
  localparam logic [NK*18-1:0] TABLE =
    {9'h075, 9'h01C, 9'h000, 9'h029, 9'h000, 9'h175, 9'h01C, 9'h06B};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tick = 1'b0;
  logic          repeat_en = 1'b0;
  logic          evt_ack = 1'b0;
  logic [NK-1:0] key_held;
  logic [NK-1:0] key_press;
  logic [NK-1:0] evt_pending;
  logic          evt_overrun;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  kbd_event_mapper #(
    .N_KEYS       (NK),
    .CODE_TABLE   (TABLE),
    .REPEAT_DELAY (DLY),
    .REPEAT_RATE  (RTE),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .tick        (tick),
    .repeat_en   (repeat_en),
    .evt_ack     (evt_ack),
    .key_held    (key_held),
    .key_press   (key_press),
    .evt_pending (evt_pending),
    .evt_overrun (evt_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: table lookup, prefix flags, ticks-until-repeat per key
  logic [8:0] tbl [NK][2];
  bit [NK-1:0] m_held, m_press, m_pend;
  bit          m_ovr;
  int          m_left [NK];
  bit          m_ext, m_brk;
  int          m_skip;
  bit          have_code, is_brk, hit;
  bit [8:0]    mcode;
  bit [NK-1:0] m_evt;

  initial begin
    for (int k = 0; k < NK; k++)
      for (int a = 0; a < 2; a++)
        tbl[k][a] = TABLE[(2*k+a)*9 +: 9];
  end

  always @(posedge clk) begin
    if (reset) begin
      m_held = '0; m_press = '0; m_pend = '0; m_ovr = 0;
      m_ext = 0; m_brk = 0; m_skip = 0;
      for (int k = 0; k < NK; k++) m_left[k] = 0;
    end else begin
      have_code = 0; is_brk = 0; mcode = '0; m_evt = '0;
      if (rx_valid) begin
        if (rx_byte == 8'h00 || rx_byte == 8'hFF) begin
          m_ext = 0; m_brk = 0; m_skip = 0;
        end else if (m_skip > 0) begin
          m_skip--;
        end else if (rx_byte == 8'hE1 && !m_ext && !m_brk) begin
          m_skip = 7;
        end else if (rx_byte == 8'hE0 && !m_ext && !m_brk) begin
          m_ext = 1;
        end else if (rx_byte == 8'hF0 && !m_brk) begin
          m_brk = 1;
        end else begin
          have_code = 1; mcode = {m_ext, rx_byte}; is_brk = m_brk;
          m_ext = 0; m_brk = 0;
        end
      end
      for (int k = 0; k < NK; k++) begin
        hit = have_code && ((tbl[k][0] != 0 && tbl[k][0] == mcode) ||
                            (tbl[k][1] != 0 && tbl[k][1] == mcode));
        if (hit && is_brk) begin
          m_held[k] = 0; m_left[k] = 0;
        end else if (hit && !m_held[k]) begin
          m_held[k] = 1; m_left[k] = DLY; m_evt[k] = 1;
        end else if (m_held[k] && repeat_en && DLY != 0 && tick && m_left[k] > 0) begin
          if (m_left[k] == 1) begin
            m_evt[k] = 1; m_left[k] = RTE;
          end else begin
            m_left[k]--;
          end
        end
      end
      m_press = m_evt;
      m_ovr = ((m_evt & m_pend) != 0) && !evt_ack;
      m_pend = (evt_ack ? '0 : m_pend) | m_evt;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_held", key_held, m_held);
      chk("model_press", key_press, m_press);
      chk("model_pending", evt_pending, m_pend);
      chk("model_overrun", evt_overrun, m_ovr);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    @(negedge clk);
    cmp_on = 1;
    @(negedge clk);
    reset = 0;
    chk("reset_held", key_held, 0);
    chk("reset_press", key_press, 0);
    chk("reset_pending", evt_pending, 0);
    chk("reset_overrun", evt_overrun, 0);

    send(8'h6B);
    chk("make_held", key_held, 4'b0001);
    chk("make_press", key_press, 4'b0001);
    chk("make_pending", evt_pending, 4'b0001);
    idle(1);
    chk("make_press_once", key_press, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      send(8'h6B);
      chk("typematic_no_press", key_press, 4'b0000);
    end
    send(8'hF0); send(8'h6B);
    chk("break_held", key_held, 4'b0000);
    chk("break_press", key_press, 4'b0000);

    send(8'hE0); send(8'h75);
    chk("ext_make_press", key_press, 4'b0010);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_break_held", key_held, 4'b0000);
    send(8'h75);
    chk("plain75_not_ch1", key_press, 4'b1000);
    send(8'hF0); send(8'h75);

    send(8'h6B);
    chk("overrun_pulse", evt_overrun, 1);
    idle(1);
    chk("overrun_once", evt_overrun, 0);
    send(8'hF0); send(8'h6B);

    evt_ack = 1'b1;
    send(8'h29);
    evt_ack = 1'b0;
    chk("ack_vs_event", evt_pending, 4'b0100);
    send(8'hF0); send(8'h29);

    send(8'h1C);
    chk("dup_fanout", key_press, 4'b1001);
    send(8'hF0); send(8'h1C);

    send(8'hE0); send(8'hFF); send(8'h75);
    chk("err_byte_resets", key_press, 4'b1000);
    send(8'hF0); send(8'h75);

    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i]);
      chk("pause_no_press", key_press, 4'b0000);
    end
    chk("pause_no_held", key_held, 4'b0000);
    send(8'h6B);
    chk("after_pause_idle", key_press, 4'b0001);
    send(8'hF0); send(8'h6B);

    repeat_en = 1'b1;
    send(8'h6B);
    for (int i = 1; i <= 8; i++) begin
      idle(9);
      pulse_tick();
      chk("repeat_tick", key_press[0], (i == 3 || i == 5 || i == 7) ? 1 : 0);
    end
    repeat_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(9);
      pulse_tick();
      chk("repeat_frozen", key_press[0], 0);
    end
    repeat_en = 1'b1;
    idle(9);
    pulse_tick();
    chk("repeat_resume", key_press[0], 1);
    pulse_tick();
    send(8'hF0);
    tick = 1'b1;
    send(8'h6B);
    tick = 1'b0;
    chk("break_beats_repeat", key_press[0], 0);
    chk("break_beats_held", key_held[0], 0);
    repeat_en = 1'b0;

    send(8'hE0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_held", key_held, 0);
    chk("midreset_pending", evt_pending, 0);
    send(8'h75);
    chk("midreset_plain", key_press, 4'b1000);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
